// File: rtl/ysyx_23060096_lsu.sv
// Load/store unit: accepts one memory op from execute, runs a single request/response
// transaction with a bounded wait, and returns an extended load result or an error code.
module ysyx_23060096_lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWr,
    input  logic [2:0]  MemOP,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [1:0]  out_err
);

    // state  | meaning
    // IDLE   | ready for a new operation
    // REQ    | memory request presented, waiting for mem_req_ready
    // WAIT   | request taken, waiting for mem_rsp_valid or timeout
    // DONE   | result presented, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic        wr_q;
    logic        in_ready_q;
    logic        mem_req_valid_q;
    logic [31:0] mem_addr_q;
    logic        mem_wen_q;
    logic [3:0]  mem_wmask_q;
    logic [31:0] mem_wdata_q;
    logic        out_valid_q;
    logic [31:0] out_rdata_q;
    logic [1:0]  out_err_q;

    logic        misalign;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] ld_data_d;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Unlisted MemOP encodings are reported as misaligned so they never reach memory.
    always_comb begin
        misalign = 1'b0;
        case (MemOP)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = addr[0];
            3'b010:         misalign = addr[1] | addr[0];
            default:        misalign = 1'b1;
        endcase
    end

    always_comb begin
        wmask_d = 4'b0000;
        wdata_d = wdata;
        case (MemOP[1:0])
            2'b00: begin
                wmask_d = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                wmask_d = 4'b0011 << addr[1:0];
                wdata_d = {2{wdata[15:0]}};
            end
            default: wmask_d = 4'b1111;
        endcase
        if (!MemWr) wmask_d = 4'b0000;
    end

    always_comb begin
        shifted   = mem_rdata >> {off_q, 3'b000};
        ld_data_d = shifted;
        case (op_q)
            3'b000:  ld_data_d = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data_d = {24'b0, shifted[7:0]};
            3'b001:  ld_data_d = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data_d = {16'b0, shifted[15:0]};
            default: ld_data_d = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            op_q            <= 3'b000;
            off_q           <= 2'b00;
            wr_q            <= 1'b0;
            in_ready_q      <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= 32'd0;
            mem_wen_q       <= 1'b0;
            mem_wmask_q     <= 4'b0000;
            mem_wdata_q     <= 32'd0;
            out_valid_q     <= 1'b0;
            out_rdata_q     <= 32'd0;
            out_err_q       <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= MemOP;
                        off_q      <= addr[1:0];
                        wr_q       <= MemWr;
                        in_ready_q <= 1'b0;
                        cnt_q      <= 8'd0;
                        if (misalign) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 2'b01;
                            out_rdata_q <= 32'd0;
                        end else begin
                            state_q         <= S_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= {addr[31:2], 2'b00};
                            mem_wen_q       <= MemWr;
                            mem_wmask_q     <= wmask_d;
                            mem_wdata_q     <= wdata_d;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state_q         <= S_WAIT;
                        mem_req_valid_q <= 1'b0;
                        mem_wen_q       <= 1'b0;
                        mem_wmask_q     <= 4'b0000;
                        cnt_q           <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the final allowed cycle beats the timeout.
                    if (mem_rsp_valid) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 2'b00;
                        out_rdata_q <= wr_q ? 32'd0 : ld_data_d;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 2'b10;
                        out_rdata_q <= 32'd0;
                        cnt_q       <= cnt_inc;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wmask     = mem_wmask_q;
    assign mem_wdata     = mem_wdata_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = out_rdata_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// Self-checking bench for ysyx_23060096_lsu: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_ysyx_23060096_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemWr;
    logic [2:0]  MemOP;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;

    int checks = 0;
    int failures = 0;

    ysyx_23060096_lsu #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .wdata(wdata), .MemWr(MemWr), .MemOP(MemOP),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_misalign(input logic [2:0] op, input logic [31:0] a);
        int sz;
        sz = op_size(op);
        if (sz == 0) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [31:0] a, input logic wr);
        int sz;
        sz = op_size(op);
        if (!wr) return 4'h0;
        if (sz == 1) return 4'(1 << int'(a[1:0]));
        if (sz == 2) return 4'(3 << int'(a[1:0]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        int sz;
        sz = op_size(op);
        if (sz == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(a[1:0]));
        case (op_size(op))
            1: begin
                v = v % 32'd256;
                if (!op[2] && v >= 32'd128) v = v - 32'd256;
            end
            2: begin
                v = v % 32'd65536;
                if (!op[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic bit m_timeout(input int rsp_delay);
        return rsp_delay < 0 || rsp_delay >= TO;
    endfunction

    // Edges counted from the accept edge (inclusive) until out_valid is visible.
    function automatic int m_latency(input bit mis, input int req_stall, input int rsp_delay);
        if (mis) return 1;
        return 2 + req_stall + (m_timeout(rsp_delay) ? TO : rsp_delay + 1);
    endfunction

    // ---------------- driver ----------------
    typedef struct {
        bit          req_seen;
        int          req_cycles;
        logic [31:0] maddr;
        logic        mwen;
        logic [3:0]  mmask;
        logic [31:0] mwdata;
        bit          req_unstable;
        int          latency;
        logic [31:0] rdata;
        logic [1:0]  err;
        bit          out_unstable;
        bit          busy_ready;
        bit          ready_at_accept;
        bit          idle_after;
        bit          hung;
    } obs_t;

    // rsp_delay: index of the WAIT cycle carrying the response, negative = never.
    task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                          input logic [2:0] op, input int req_stall, input int rsp_delay,
                          input int out_stall, input logic [31:0] rd, output obs_t o);
        int  edges;
        int  wait_idx;
        int  iter;
        bit  in_wait;
        bit  hs;
        o = '{default: 0};
        @(negedge clk);
        o.ready_at_accept = in_ready;
        in_valid = 1'b1; addr = a; wdata = wd; MemWr = wr; MemOP = op;
        @(posedge clk);
        edges = 1; in_wait = 0; wait_idx = 0; iter = 0;
        @(negedge clk);
        // keep in_valid high with junk while busy: it must be ignored
        addr = $urandom; wdata = $urandom; MemWr = 1'($urandom); MemOP = 3'($urandom);
        while (!out_valid && iter < 400) begin
            iter++;
            if (in_ready) o.busy_ready = 1;
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (!o.req_seen) begin
                    o.req_seen = 1; o.maddr = mem_addr; o.mwen = mem_wen;
                    o.mmask = mem_wmask; o.mwdata = mem_wdata;
                end else if (mem_addr !== o.maddr || mem_wen !== o.mwen ||
                             mem_wmask !== o.mmask || mem_wdata !== o.mwdata) begin
                    o.req_unstable = 1;
                end
                o.req_cycles++;
                mem_req_ready = (o.req_cycles > req_stall);
                if (!mem_req_ready) begin
                    mem_rsp_valid = 1'($urandom);
                    mem_rdata = $urandom;
                end
            end else if (in_wait && wait_idx == rsp_delay) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = rd;
            end
            hs = mem_req_valid && mem_req_ready;
            @(posedge clk);
            edges++;
            if (in_wait) wait_idx++;
            if (hs) begin in_wait = 1; wait_idx = 0; end
            @(negedge clk);
            addr = $urandom; wdata = $urandom;
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        if (!out_valid) begin
            o.hung = 1;
            in_valid = 1'b0;
            return;
        end
        o.latency = edges; o.rdata = out_rdata; o.err = out_err;
        if (mem_req_valid) o.req_seen = 1;
        for (int i = 0; i < out_stall; i++) begin
            if (in_ready) o.busy_ready = 1;
            mem_rsp_valid = 1'($urandom);
            mem_rdata = $urandom;
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || out_rdata !== o.rdata || out_err !== o.err) o.out_unstable = 1;
            if (mem_req_valid) o.req_seen = 1;
        end
        mem_rsp_valid = 1'b0;
        if (in_ready) o.busy_ready = 1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        o.idle_after = in_ready && !out_valid && !mem_req_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_rdata !== 32'd0) begin failures++; $display("FAIL reset_out_rdata: got %h expected 0", out_rdata); end
        checks++; if (out_err !== 2'b00) begin failures++; $display("FAIL reset_out_err: got %b expected 00", out_err); end
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b expected 0", mem_wen); end
        checks++; if (mem_wmask !== 4'b0000) begin failures++; $display("FAIL reset_wmask: got %b expected 0000", mem_wmask); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb_sign();
        obs_t o;
        run_op(32'h8000_0003, $urandom, 1'b0, 3'b000, 0, 0, 0, 32'h80AA_BBCC, o);
        checks++; if (o.hung) begin failures++; $display("FAIL lb_hang: got no out_valid expected out_valid"); end
        checks++; if (o.rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata: got %h expected ffffff80", o.rdata); end
        checks++; if (o.err !== 2'b00) begin failures++; $display("FAIL lb_err: got %b expected 00", o.err); end
        checks++; if (o.latency != 3) begin failures++; $display("FAIL lb_latency: got %0d expected 3", o.latency); end
        checks++; if (o.maddr !== 32'h8000_0000) begin failures++; $display("FAIL lb_addr: got %h expected 80000000", o.maddr); end
        checks++; if (o.mwen !== 1'b0 || o.mmask !== 4'b0000) begin failures++; $display("FAIL lb_wen_mask: got %b/%b expected 0/0000", o.mwen, o.mmask); end
    endtask

    task automatic test_sh();
        obs_t o;
        run_op(32'h8000_0002, 32'h0000_1234, 1'b1, 3'b001, 0, 0, 0, $urandom, o);
        checks++; if (o.mmask !== 4'b1100) begin failures++; $display("FAIL sh_mask: got %b expected 1100", o.mmask); end
        checks++; if (o.mwdata[31:16] !== 16'h1234) begin failures++; $display("FAIL sh_wdata: got %h expected 1234", o.mwdata[31:16]); end
        checks++; if (o.mwen !== 1'b1) begin failures++; $display("FAIL sh_wen: got %b expected 1", o.mwen); end
        checks++; if (o.rdata !== 32'd0 || o.err !== 2'b00) begin failures++; $display("FAIL sh_result: got %h/%b expected 0/00", o.rdata, o.err); end
        checks++; if (o.latency != 3) begin failures++; $display("FAIL sh_latency: got %0d expected 3", o.latency); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(32'h8000_0001, $urandom, 1'b0, 3'b010, 0, 0, 2, $urandom, o);
        checks++; if (o.latency != 1) begin failures++; $display("FAIL mis_latency: got %0d expected 1", o.latency); end
        checks++; if (o.err !== 2'b01) begin failures++; $display("FAIL mis_err: got %b expected 01", o.err); end
        checks++; if (o.req_seen) begin failures++; $display("FAIL mis_req: got request expected none"); end
        checks++; if (o.rdata !== 32'd0) begin failures++; $display("FAIL mis_rdata: got %h expected 0", o.rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
        logic [31:0] rd;
        run_op(32'h8000_0100, $urandom, 1'b0, 3'b010, 0, -1, 0, $urandom, o);
        checks++; if (o.err !== 2'b10) begin failures++; $display("FAIL to_err: got %b expected 10", o.err); end
        checks++; if (o.latency != 2 + TO) begin failures++; $display("FAIL to_latency: got %0d expected %0d", o.latency, 2 + TO); end
        checks++; if (o.rdata !== 32'd0) begin failures++; $display("FAIL to_rdata: got %h expected 0", o.rdata); end
        rd = $urandom;
        run_op(32'h8000_0104, $urandom, 1'b0, 3'b010, 0, TO - 1, 0, rd, o);
        checks++; if (o.err !== 2'b00) begin failures++; $display("FAIL late_rsp_err: got %b expected 00", o.err); end
        checks++; if (o.rdata !== rd) begin failures++; $display("FAIL late_rsp_rdata: got %h expected %h", o.rdata, rd); end
        checks++; if (o.latency != 2 + TO) begin failures++; $display("FAIL late_rsp_latency: got %0d expected %0d", o.latency, 2 + TO); end
    endtask

    task automatic test_stall();
        obs_t o;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [2:0]  op;
        for (int k = 0; k < 2; k++) begin
            op = (k == 0) ? 3'b000 : 3'b101;
            a  = (k == 0) ? 32'h8000_0011 : 32'h8000_0016;
            wd = $urandom; rd = $urandom;
            run_op(a, wd, 1'(k == 0), op, 5, 1, 3, rd, o);
            checks++; if (o.req_cycles != 6) begin failures++; $display("FAIL stall_req_cycles: got %0d expected 6", o.req_cycles); end
            checks++; if (o.req_unstable || o.out_unstable) begin failures++; $display("FAIL stall_stable: got req=%0d out=%0d unstable expected 0/0", o.req_unstable, o.out_unstable); end
            checks++; if (o.busy_ready) begin failures++; $display("FAIL stall_in_ready: got in_ready=1 while busy expected 0"); end
            checks++; if (o.mmask !== m_mask(op, a, 1'(k == 0))) begin failures++; $display("FAIL stall_mask: got %b expected %b", o.mmask, m_mask(op, a, 1'(k == 0))); end
            checks++; if (o.rdata !== ((k == 0) ? 32'd0 : m_load(op, a, rd))) begin failures++; $display("FAIL stall_rdata: got %h expected %h", o.rdata, (k == 0) ? 32'd0 : m_load(op, a, rd)); end
            checks++; if (o.latency != m_latency(0, 5, 1)) begin failures++; $display("FAIL stall_latency: got %0d expected %0d", o.latency, m_latency(0, 5, 1)); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        logic [31:0] rd;
        rd = $urandom;
        run_op(32'h8000_0020, 32'hCAFE_F00D, 1'b1, 3'b010, 0, 0, 0, $urandom, o1);
        run_op(32'h8000_0021, $urandom, 1'b0, 3'b100, 0, 0, 0, rd, o2);
        checks++; if (!o1.idle_after || !o2.ready_at_accept) begin failures++; $display("FAIL b2b_ready: got idle=%0d ready=%0d expected 1/1", o1.idle_after, o2.ready_at_accept); end
        checks++; if (o1.mwdata !== 32'hCAFE_F00D || o1.mmask !== 4'hF) begin failures++; $display("FAIL b2b_sw: got %h/%b expected cafef00d/1111", o1.mwdata, o1.mmask); end
        checks++; if (o2.rdata !== {24'h0, rd[15:8]}) begin failures++; $display("FAIL b2b_lbu: got %h expected %h", o2.rdata, {24'h0, rd[15:8]}); end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        int   bad;
        logic [31:0] rd;
        @(negedge clk);
        in_valid = 1'b1; addr = 32'h8000_0040; MemWr = 1'b0; MemOP = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_hs: got ready=%b req=%b out=%b expected 1/0/0", in_ready, mem_req_valid, out_valid); end
        checks++; if (out_rdata !== 32'd0 || out_err !== 2'b00 || mem_wen !== 1'b0 || mem_wmask !== 4'b0) begin failures++; $display("FAIL rst_wait_data: got %h/%b/%b/%b expected 0/00/0/0000", out_rdata, out_err, mem_wen, mem_wmask); end
        @(negedge clk);
        rstn = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || mem_req_valid || !in_ready) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rst_stale_rsp: got %0d active cycles expected 0", bad); end
        rd = $urandom;
        run_op(32'h8000_0044, $urandom, 1'b0, 3'b010, 0, 0, 0, rd, o);
        checks++; if (o.rdata !== rd || o.err !== 2'b00) begin failures++; $display("FAIL rst_recover: got %h/%b expected %h/00", o.rdata, o.err, rd); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0]  ops[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [2:0]  op;
        logic        wr;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        bit          mis;
        int          rs;
        int          rsp;
        int          os;
        for (int n = 0; n < 80; n++) begin
            a = $urandom; wd = $urandom; rd = $urandom; wr = 1'($urandom);
            op  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : ops[$urandom_range(0, 4)];
            rs  = $urandom_range(0, 2);
            rsp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            os  = $urandom_range(0, 2);
            run_op(a, wd, wr, op, rs, rsp, os, rd, o);
            mis = m_misalign(op, a);
            exp_err = mis ? 2'b01 : (m_timeout(rsp) ? 2'b10 : 2'b00);
            exp_rd  = (exp_err != 2'b00 || wr) ? 32'd0 : m_load(op, a, rd);
            checks++; if (o.err !== exp_err) begin failures++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, o.err, exp_err); end
            checks++; if (o.rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, o.rdata, exp_rd); end
            checks++; if (o.latency != m_latency(mis, rs, rsp)) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, o.latency, m_latency(mis, rs, rsp)); end
            checks++; if (o.req_seen != !mis) begin failures++; $display("FAIL rnd_req_seen[%0d]: got %0d expected %0d", n, o.req_seen, !mis); end
            checks++; if (o.busy_ready || !o.ready_at_accept || !o.idle_after) begin failures++; $display("FAIL rnd_ready[%0d]: got busy=%0d acc=%0d idle=%0d expected 0/1/1", n, o.busy_ready, o.ready_at_accept, o.idle_after); end
            checks++; if (o.req_unstable || o.out_unstable) begin failures++; $display("FAIL rnd_stable[%0d]: got req=%0d out=%0d expected 0/0", n, o.req_unstable, o.out_unstable); end
            if (!mis) begin
                checks++; if (o.maddr !== {a[31:2], 2'b00} || o.mwen !== wr) begin failures++; $display("FAIL rnd_addr_wen[%0d]: got %h/%b expected %h/%b", n, o.maddr, o.mwen, {a[31:2], 2'b00}, wr); end
                checks++; if (o.mmask !== m_mask(op, a, wr)) begin failures++; $display("FAIL rnd_mask[%0d]: got %b expected %b", n, o.mmask, m_mask(op, a, wr)); end
                if (wr) begin
                    checks++; if (o.mwdata !== m_wdata(op, wd)) begin failures++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, o.mwdata, m_wdata(op, wd)); end
                end
            end
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; addr = '0; wdata = '0; MemWr = 1'b0; MemOP = 3'b000;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        test_reset();
        test_lb_sign();
        test_sh();
        test_misaligned();
        test_timeout();
        test_stall();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
